// File: rtl/smag_pkg.sv
// Shared widths, FSM states and op encoding for the sign-magnitude add/sub arbiter.
// Also provides the result packer that enforces the no-negative-zero rule.
package smag_pkg;

  localparam int MAG_W = 17;
  localparam int OP_W  = 18;
  localparam int RES_W = 19;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LATCH   = 2'd1,
    COMPUTE = 2'd2,
    RESP    = 2'd3
  } state_e;

  localparam logic OP_SUB = 1'b0;
  localparam logic OP_ADD = 1'b1;

  // A zero magnitude always leaves with a positive sign.
  function automatic logic [RES_W-1:0] smag_pack(input logic sign,
                                                 input logic [RES_W-2:0] mag);
    return {sign & (|mag), mag};
  endfunction

endpackage

// File: rtl/smag_sub_arbiter_rr_arbiter.sv
// Round-robin grant: first asserted request at or above rr_ptr_i, wrapping to index 0.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  rr_ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_valid_o
);

  always_comb begin
    grant_o     = '0;
    idx_o       = '0;
    any_valid_o = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (!any_valid_o && req_i[j] && (IDW'(j) >= rr_ptr_i)) begin
        any_valid_o = 1'b1;
        grant_o[j]  = 1'b1;
        idx_o       = IDW'(j);
      end
    end
    // Nothing at or above the pointer: wrap and take the lowest request.
    for (int j = 0; j < NREQ; j++) begin
      if (!any_valid_o && req_i[j]) begin
        any_valid_o = 1'b1;
        grant_o[j]  = 1'b1;
        idx_o       = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/smag_sub_arbiter.sv
// Round-robin shared 18-bit sign-magnitude add/subtract unit with valid/ready on
// both sides: IDLE grants, LATCH splits and compares, COMPUTE forms the result, RESP holds it.
module smag_sub_arbiter
  import smag_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*OP_W-1:0]   req_a,
  input  logic [NREQ*OP_W-1:0]   req_b,
  input  logic [NREQ-1:0]        req_op,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [RES_W-1:0]       resp_z,
  output logic [IDW-1:0]         resp_id,
  output logic                   busy,
  output logic [15:0]            op_count
);

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic             resp_valid_q, resp_valid_d;
  logic             busy_q, busy_d;
  logic [15:0]      op_count_q, op_count_d;
  logic [RES_W-1:0] resp_z_q;
  logic [IDW-1:0]   resp_id_q;

  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_idx;
  logic             any_valid;
  logic             accept;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_i       (req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (gnt),
    .idx_o       (gnt_idx),
    .any_valid_o (any_valid)
  );

  assign req_ready = (rst && (state_q == IDLE)) ? gnt : '0;
  assign accept    = (state_q == IDLE) && any_valid;

  logic [OP_W-1:0] a_sel, b_sel;
  logic            op_sel;

  always_comb begin
    a_sel  = '0;
    b_sel  = '0;
    op_sel = OP_SUB;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        a_sel  = req_a[i*OP_W +: OP_W];
        b_sel  = req_b[i*OP_W +: OP_W];
        op_sel = req_op[i];
      end
    end
  end

  logic [OP_W-1:0]  a_q, b_q;
  logic             op_q;
  logic [IDW-1:0]   id_q;

  // LATCH stage: split, fold op into B's sign, treat -0 as +0, compare magnitudes
  logic [MAG_W-1:0] a_mag_w, b_mag_w;
  logic             a_sgn_w, b_sgn_w;

  assign a_mag_w = a_q[MAG_W-1:0];
  assign b_mag_w = b_q[MAG_W-1:0];
  assign a_sgn_w = a_q[OP_W-1] & (|a_mag_w);
  assign b_sgn_w = (b_q[OP_W-1] ^ (op_q == OP_SUB)) & (|b_mag_w);

  logic [MAG_W-1:0] a_mag_q, b_mag_q;
  logic             a_sgn_q, b_sgn_q;
  logic             gt_q, eq_q;

  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= a_sel;
      b_q  <= b_sel;
      op_q <= op_sel;
      id_q <= gnt_idx;
    end
    if (state_q == LATCH) begin
      a_mag_q <= a_mag_w;
      b_mag_q <= b_mag_w;
      a_sgn_q <= a_sgn_w;
      b_sgn_q <= b_sgn_w;
      gt_q    <= (a_mag_w > b_mag_w);
      eq_q    <= (a_mag_w == b_mag_w);
    end
  end

  // COMPUTE stage: add when effective signs agree, else subtract smaller from larger
  logic [OP_W-1:0]  sum_mag;
  logic [MAG_W-1:0] dif_mag;
  logic             res_sgn;
  logic [OP_W-1:0]  res_mag;
  logic [RES_W-1:0] res_z;

  assign sum_mag = {1'b0, a_mag_q} + {1'b0, b_mag_q};
  assign dif_mag = gt_q ? (a_mag_q - b_mag_q) : (b_mag_q - a_mag_q);

  always_comb begin
    res_sgn = 1'b0;
    res_mag = '0;
    if (a_sgn_q == b_sgn_q) begin
      res_sgn = a_sgn_q;
      res_mag = sum_mag;
    end else if (eq_q) begin
      res_sgn = 1'b0;
      res_mag = '0;
    end else if (gt_q) begin
      res_sgn = a_sgn_q;
      res_mag = {1'b0, dif_mag};
    end else begin
      res_sgn = b_sgn_q;
      res_mag = {1'b0, dif_mag};
    end
  end

  assign res_z = smag_pack(res_sgn, res_mag);

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    resp_valid_d = resp_valid_q;
    op_count_d   = op_count_q;
    unique case (state_q)
      IDLE: begin
        if (any_valid) state_d = LATCH;
      end
      LATCH: begin
        state_d = COMPUTE;
      end
      COMPUTE: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          op_count_d   = op_count_q + 16'd1;
          rr_ptr_d     = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
        end
      end
      default: begin
        state_d      = IDLE;
        resp_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      op_count_q   <= '0;
      resp_z_q     <= '0;
      resp_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
      op_count_q   <= op_count_d;
      if (state_q == COMPUTE) begin
        resp_z_q  <= res_z;
        resp_id_q <= id_q;
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_z     = resp_z_q;
  assign resp_id    = resp_id_q;
  assign busy       = busy_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_smag_sub_arbiter.sv
// Bench for smag_sub_arbiter: integer-arithmetic transaction model checked every cycle,
// directed operand cases, fairness, backpressure, mid-operation reset and random traffic.
module tb_smag_sub_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*18-1:0] req_a = '0;
  logic [NREQ*18-1:0] req_b = '0;
  logic [NREQ-1:0]   req_op = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b1;
  logic [18:0]       resp_z;
  logic [IDW-1:0]    resp_id;
  logic              busy;
  logic [15:0]       op_count;

  int n_checks = 0;
  int n_err    = 0;

  smag_sub_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_z     (resp_z),
    .resp_id    (resp_id),
    .busy       (busy),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string nm);
    n_checks++;
    n_err++;
    $display("FAIL %s: timed out waiting at %0t", nm, $time);
  endtask

  // Reference arithmetic: signed integers, then back to sign-magnitude.
  function automatic logic [18:0] ref_calc(input logic [17:0] a, input logic [17:0] b,
                                           input logic op);
    int va, vb, r;
    va = int'({15'b0, a[16:0]});
    vb = int'({15'b0, b[16:0]});
    if (a[17]) va = -va;
    if (b[17]) vb = -vb;
    r = op ? (va + vb) : (va - vb);
    if (r < 0) return {1'b1, 18'(-r)};
    return {1'b0, 18'(r)};
  endfunction

  function automatic int ref_grant(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // Transaction model: a granted op shows its response two edges later and
  // stays until resp_ready; op_count and the pointer move on that acceptance.
  bit          m_pend = 0;
  int          m_age  = 0;
  logic [18:0] m_res  = '0;
  logic [18:0] m_z    = '0;
  int          m_id   = 0;
  int          m_idout = 0;
  int          m_ptr  = 0;
  int          m_cnt  = 0;

  always @(negedge clk) begin
    int g;
    logic [NREQ-1:0] er;
    if (!rst) begin
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_resp_z", 32'(resp_z), 32'd0);
      chk("rst_resp_id", 32'(resp_id), 32'd0);
      chk("rst_op_count", 32'(op_count), 32'd0);
      m_pend = 0; m_age = 0; m_z = '0; m_idout = 0; m_ptr = 0; m_cnt = 0;
    end else begin
      g  = ref_grant(req_valid, m_ptr);
      er = (!m_pend && g >= 0) ? NREQ'(1 << g) : '0;
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("busy", 32'(busy), 32'(m_pend));
      chk("resp_valid", 32'(resp_valid), 32'(m_pend && m_age >= 2));
      chk("resp_z", 32'(resp_z), 32'(m_z));
      chk("resp_id", 32'(resp_id), 32'(m_idout));
      chk("op_count", 32'(op_count), 32'(m_cnt));
      if (!m_pend) begin
        if (g >= 0) begin
          m_pend = 1;
          m_age  = 0;
          m_id   = g;
          m_res  = ref_calc(req_a[g*18 +: 18], req_b[g*18 +: 18], req_op[g]);
        end
      end else if (m_age < 2) begin
        m_age++;
        if (m_age == 2) begin
          m_z     = m_res;
          m_idout = m_id;
        end
      end else if (resp_ready) begin
        m_pend = 0;
        m_cnt  = (m_cnt + 1) & 16'hFFFF;
        m_ptr  = (m_id + 1) % NREQ;
      end
    end
  end

  task automatic set_req(input int i, input logic [17:0] a, input logic [17:0] b,
                         input logic op);
    req_a[i*18 +: 18] = a;
    req_b[i*18 +: 18] = b;
    req_op[i]         = op;
  endtask

  function automatic logic [17:0] rnd_opnd();
    logic [16:0] m;
    case ($urandom_range(0, 3))
      0:       m = '0;
      1:       m = '1;
      default: m = 17'($urandom);
    endcase
    return {1'($urandom_range(0, 1)), m};
  endfunction

  // All tasks below start and end just after a rising edge.
  task automatic do_reset();
    req_valid = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic wait_grant(input int i, output bit ok);
    ok = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input string nm);
    bit done;
    done = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!busy && req_valid == '0) begin
        done = 1;
        break;
      end
    end
    if (!done) fail_timeout(nm);
    @(posedge clk); #1;
  endtask

  task automatic run_op(input string nm, input int i, input logic [17:0] a,
                        input logic [17:0] b, input logic op, input logic [18:0] exp_z);
    bit ok;
    int k;
    set_req(i, a, b, op);
    req_valid[i] = 1'b1;
    wait_grant(i, ok);
    if (!ok) begin
      fail_timeout(nm);
      req_valid[i] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      if (resp_valid) break;
      @(posedge clk);
      k++;
    end
    if (k >= 20) begin
      fail_timeout(nm);
      return;
    end
    chk({nm, "_lat"}, 32'(k), 32'd2);
    chk({nm, "_z"}, 32'(resp_z), 32'(exp_z));
    chk({nm, "_id"}, 32'(resp_id), 32'(i));
    @(posedge clk); #1;
  endtask

  initial begin
    int grants[$];
    int exp_order[6];
    logic [NREQ-1:0] rdy, vld;
    bit ok;
    int k;

    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    chk("pin_sub_pos", 32'(ref_calc(18'h00064, 18'h0001E, 1'b0)), 32'h00046);
    chk("pin_sub_neg", 32'(ref_calc(18'h00005, 18'h00009, 1'b0)), 32'h40004);
    chk("pin_max_add", 32'(ref_calc(18'h1FFFF, 18'h1FFFF, 1'b1)), 32'h3FFFE);
    chk("pin_negzero", 32'(ref_calc(18'h20000, 18'h00000, 1'b1)), 32'h00000);

    resp_ready = 1'b1;
    run_op("r0_100m30", 0, 18'h00064, 18'h0001E, 1'b0, 19'h00046);
    run_op("r1_5m9",    1, 18'h00005, 18'h00009, 1'b0, 19'h40004);
    run_op("r1_m100m50",1, 18'h20064, 18'h00032, 1'b0, 19'h40096);
    run_op("r2_maxadd", 2, 18'h1FFFF, 18'h1FFFF, 1'b1, 19'h3FFFE);
    run_op("r2_7m7",    2, 18'h00007, 18'h00007, 1'b0, 19'h00000);
    run_op("r2_nzero",  2, 18'h20000, 18'h00000, 1'b1, 19'h00000);
    @(negedge clk);
    chk("count_after6", 32'(op_count), 32'd6);
    @(posedge clk); #1;

    // Fairness with every requester continuously valid.
    do_reset();
    exp_order = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < NREQ; i++) set_req(i, rnd_opnd(), rnd_opnd(), 1'($urandom_range(0, 1)));
    req_valid = '1;
    k = 0;
    while (grants.size() < 6 && k < 100) begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk); #1;
      k++;
      for (int i = 0; i < NREQ; i++) begin
        if (rdy[i]) begin
          grants.push_back(i);
          set_req(i, rnd_opnd(), rnd_opnd(), 1'($urandom_range(0, 1)));
        end
      end
    end
    if (grants.size() < 6) fail_timeout("fair_grants");
    for (int i = 0; i < 6 && i < grants.size(); i++)
      chk($sformatf("fair_grant%0d", i), 32'(grants[i]), 32'(exp_order[i]));
    req_valid = '0;
    wait_idle("fair_idle");

    // Backpressure: response must hold while resp_ready is low.
    do_reset();
    resp_ready = 1'b0;
    set_req(3, 18'h0000A, 18'h20003, 1'b1);
    req_valid[3] = 1'b1;
    wait_grant(3, ok);
    if (!ok) fail_timeout("bp_grant");
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    req_valid[0] = 1'b1;
    set_req(0, 18'h00001, 18'h00001, 1'b1);
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      if (resp_valid) break;
      k++;
    end
    if (k >= 20) fail_timeout("bp_resp");
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_z", 32'(resp_z), 32'h00007);
      chk("bp_id", 32'(resp_id), 32'd3);
      chk("bp_ready0", 32'(req_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_count", 32'(op_count), 32'd1);
    chk("bp_released", 32'(resp_valid), 32'd0);
    wait_grant(0, ok);
    if (!ok) fail_timeout("bp_next_grant");
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_idle("bp_idle");

    // Reset while an operation is in COMPUTE.
    set_req(1, 18'h00003, 18'h00004, 1'b1);
    req_valid[1] = 1'b1;
    wait_grant(1, ok);
    if (!ok) fail_timeout("rc_grant");
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    chk("rc_busy_pre", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("rc_valid", 32'(resp_valid), 32'd0);
    chk("rc_busy", 32'(busy), 32'd0);
    chk("rc_count", 32'(op_count), 32'd0);
    chk("rc_z", 32'(resp_z), 32'd0);
    chk("rc_id", 32'(resp_id), 32'd0);
    set_req(2, 18'h00010, 18'h00001, 1'b0);
    set_req(3, 18'h00020, 18'h00002, 1'b0);
    req_valid = 4'b1100;
    #1 chk("rc_ready_in_rst", 32'(req_ready), 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rc_first_grant", 32'(req_ready), 32'h4);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      if (resp_valid) break;
      k++;
    end
    if (k >= 20) fail_timeout("rc_resp");
    chk("rc_resp_id", 32'(resp_id), 32'd2);
    chk("rc_resp_z", 32'(resp_z), 32'h0000F);
    @(posedge clk); #1;
    wait_grant(3, ok);
    if (!ok) fail_timeout("rc_grant3");
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    wait_idle("rc_idle");

    // Random traffic: random validity, withdrawals, operands and backpressure.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rdy = req_ready;
      vld = req_valid;
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (rdy[i] && vld[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          set_req(i, rnd_opnd(), rnd_opnd(), 1'($urandom_range(0, 1)));
        end else if (!req_valid[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            set_req(i, rnd_opnd(), rnd_opnd(), 1'($urandom_range(0, 1)));
            req_valid[i] = 1'b1;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      resp_ready = ($urandom_range(0, 9) < 7);
    end
    req_valid  = '0;
    resp_ready = 1'b1;
    wait_idle("rand_drain");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/smag_sub_arbiter.md
Name: smag_sub_arbiter

Overview:
- Shares one 18-bit sign-magnitude add/subtract datapath between NREQ requesters.
- Round-robin arbitration with a valid/ready handshake. The winner's operands are latched, the op runs over a fixed multi-cycle sequence, and the 19-bit sign-magnitude result is returned tagged with the requester id.
- Sits between the subtractor datapath and its client blocks.
- Replaces free-running, state-counter sequencing with an explicit handshake-driven FSM.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester id width; must be >= clog2(NREQ).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester operation valid.
- req_ready  out  NREQ  per-requester accept, one-hot or zero.
- req_a  in  NREQ*18  operand A per requester, slice i = [18i+17:18i]. Bit 17 is sign, [16:0] is magnitude.
- req_b  in  NREQ*18  operand B per requester, same format as req_a.
- req_op  in  NREQ  per-requester op: 0 = A-B, 1 = A+B.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts result.
- resp_z  out  19  result. Bit 18 is sign, [17:0] is magnitude.
- resp_id  out  IDW  index of the requester the result belongs to.
- busy  out  1  high in any state other than IDLE.
- op_count  out  16  completed operations; wraps 0xFFFF -> 0.

Behaviour:
- Reset (rst=0, async): FSM=IDLE, rr_ptr=0, resp_valid=0, resp_z=0, resp_id=0, op_count=0, busy=0, req_ready=0.
  - Reset mid-operation discards the in-flight op; no response is issued for it.
- IDLE
  - Combinational grant: the first i with req_valid[i]=1, searching from rr_ptr upward with wrap. Assert req_ready[i] only.
  - On the handshake edge: latch a, b, op and id=i; go to LATCH.
  - No valid request: stay in IDLE, req_ready=0.
- LATCH (1 cycle)
  - Split into sign and magnitude.
  - Effective B sign = b[17] XOR (op==0).
  - Magnitude compare: gt, lt, eq.
- COMPUTE (1 cycle)
  - Effective signs equal: mag = a_mag + b_mag (18-bit, no overflow possible); sign = a sign.
  - Effective signs differ: mag = |a_mag - b_mag|; sign = sign of the larger magnitude.
  - Result magnitude 0: sign forced to 0. No negative zero is ever output.
  - Input negative zero (sign=1, mag=0) is treated as +0.
  - Load resp_z and resp_id; go to RESP.
- RESP
  - resp_valid=1; resp_z and resp_id held stable.
  - On resp_valid & resp_ready: resp_valid=0, op_count++, rr_ptr = id+1 mod NREQ, go to IDLE.
  - Backpressure holds RESP indefinitely. req_ready stays 0 in every state except IDLE.
- Timing
  - Handshake at edge N gives resp_valid high after edge N+2.
  - Peak throughput: one op per 4 cycles with resp_ready tied high.
- Requester rules
  - A requester keeps req_valid and its operands stable until it sees req_ready.
  - Deasserting req_valid before the grant is legal; that requester is simply skipped.
- Guarantees
  - Outputs are registered, except req_ready, which is combinational from FSM state, rr_ptr and req_valid.
  - Fairness: with every requester continuously valid, each is granted once per NREQ grants.

Decomposition:
- Package smag_pkg:
  - Widths: MAG_W=17, OP_W=18, RES_W=19.
  - State enum: IDLE, LATCH, COMPUTE, RESP.
  - Op encoding: OP_SUB=0, OP_ADD=1.
- One sub-module, rr_arbiter (NREQ):
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, encoded index, any_valid.
- The sign-magnitude arithmetic stays inline in the COMPUTE stage.

Test Plan:
- Req0: a=18'h00064 (+100), b=18'h0001E (+30), op=SUB -> resp_z=19'h00046, resp_id=0, resp_valid 2 cycles after the handshake.
- Req1: a=+5 (18'h00005), b=+9 (18'h00009), op=SUB -> resp_z=19'h40004 (-4). Then a=-100 (18'h20064), b=+50 (18'h00032), op=SUB -> resp_z=19'h40096 (-150).
- Req2: a=b=18'h1FFFF, op=ADD -> resp_z=19'h3FFFE, sign 0. Then a=+7, b=+7, op=SUB -> 19'h00000. Then a=18'h20000 (-0), b=0, op=ADD -> 19'h00000.
- All 4 req_valid held high, resp_ready=1 -> grant order 0,1,2,3,0,1. op_count increments once per response. resp_id matches the grant.
- resp_ready=0 for 10 cycles in RESP -> resp_z and resp_id stable, req_ready stays 0, busy=1. Releasing resp_ready completes the op, op_count+1.
- Drop rst during COMPUTE -> all outputs return to reset values immediately. After release, no stale response appears, and the next grant goes to the lowest valid index.
